// File: rtl/ycc_to_rgb_conversion_if.sv
// Wishbone classic slave bus for the YCbCr -> RGB converter.
// Handshake: a request is CYC_I && STB_I sampled on a rising edge while
// ACK_O is low; ACK_O answers it as a one-cycle pulse on the next cycle,
// and DAT_O carries read data only during that pulse (zero otherwise).
interface ycc_to_rgb_conversion_if;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic [31:0] ADR_I;
    logic        WE_I;
    logic        STB_I;
    logic        CYC_I;
    logic [3:0]  SEL_I;
    logic        ACK_O;

    modport master (
        output DAT_I, ADR_I, WE_I, STB_I, CYC_I, SEL_I,
        input  DAT_O, ACK_O
    );

    modport slave (
        input  DAT_I, ADR_I, WE_I, STB_I, CYC_I, SEL_I,
        output DAT_O, ACK_O
    );
endinterface

// File: rtl/ycc_to_rgb_conversion.sv
// YCbCr -> RGB converter behind a Wishbone slave port.
// Registers: 0x0 write {Y,Cb,Cr} in [23:0]; 0x4 read {8'h0,R,G,B} (clears
// VALID); 0x8 read {29'h0,OVR,BUSY,VALID} (clears OVR).
// One shared signed multiplier walks M0..M3, then CLIP forms the channels.
// Optional macro YCC2RGB_SAT_EN: clamp each channel to 0..255 instead of
// keeping the low 8 bits (two's-complement wrap).
module ycc_to_rgb_conversion #(
    parameter int COEF_FRAC = 16,
    parameter int K_CR_R    = 91881,
    parameter int K_CB_G    = 22554,
    parameter int K_CR_G    = 46802,
    parameter int K_CB_B    = 116130
) (
    input logic                      CLK_I,
    input logic                      RST_I,
    ycc_to_rgb_conversion_if.slave   wb
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_M0   = 3'd1,
        S_M1   = 3'd2,
        S_M2   = 3'd3,
        S_M3   = 3'd4,
        S_CLIP = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               ack_q, ack_d;
    logic [31:0]        dat_o_q, dat_o_d;
    logic [23:0]        result_q, result_d;
    logic               valid_q, valid_d;
    logic               ovr_q, ovr_d;
    logic [7:0]         y_q, y_d, cb_q, cb_d, cr_q, cr_d;
    logic signed [27:0] acc_r_q, acc_r_d, acc_g_q, acc_g_d, acc_b_q, acc_b_d;

    logic               req;
    logic               wr_conv;
    logic               busy;
    logic [3:0]         adr;
    logic signed [8:0]  dcb, dcr;
    logic signed [17:0] mul_a;
    logic signed [8:0]  mul_b;
    logic signed [26:0] prod;
    logic signed [27:0] prod_ext;
    logic signed [27:0] y_ext;
    logic               unused_bits;

    // Only ADR_I[3:0] and DAT_I[23:0] carry meaning.
    assign unused_bits = ^{wb.ADR_I[31:4], wb.DAT_I[31:24]};

    assign adr      = wb.ADR_I[3:0];
    assign req      = wb.CYC_I && wb.STB_I && !ack_q;
    assign wr_conv  = req && wb.WE_I && (adr == 4'h0) && (wb.SEL_I == 4'b1111);
    assign busy     = (state_q != S_IDLE);
    assign dcb      = $signed({1'b0, cb_q}) - 9'sd128;
    assign dcr      = $signed({1'b0, cr_q}) - 9'sd128;
    assign prod     = $signed({{9{mul_a[17]}}, mul_a}) * $signed({{18{mul_b[8]}}, mul_b});
    assign prod_ext = {prod[26], prod};
    assign y_ext    = $signed(28'(y_q) << COEF_FRAC);

    assign wb.ACK_O = ack_q;
    assign wb.DAT_O = dat_o_q;

    // Turn a 28-bit accumulator into one 8-bit channel (floor shift, then clamp or wrap).
    function automatic logic [7:0] to_chan(input logic signed [27:0] acc);
        logic signed [27:0] s;
        s = acc >>> COEF_FRAC;
`ifdef YCC2RGB_SAT_EN
        if (s < 28'sd0)        return 8'h00;
        else if (s > 28'sd255) return 8'hFF;
        else                   return s[7:0];
`else
        return s[7:0];
`endif
    endfunction

    // Select the coefficient / chroma pair for the shared multiplier.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state_q)
            S_M0: begin mul_a = 18'(K_CR_R); mul_b = dcr; end
            S_M1: begin mul_a = 18'(K_CB_G); mul_b = dcb; end
            S_M2: begin mul_a = 18'(K_CR_G); mul_b = dcr; end
            S_M3: begin mul_a = 18'(K_CB_B); mul_b = dcb; end
            default: ;
        endcase
    end

    // Next state: FSM sequencing, accumulators, bus responses and status flags.
    always_comb begin
        state_d  = state_q;
        ack_d    = req;
        dat_o_d  = 32'h0;
        result_d = result_q;
        valid_d  = valid_q;
        ovr_d    = ovr_q;
        y_d      = y_q;
        cb_d     = cb_q;
        cr_d     = cr_q;
        acc_r_d  = acc_r_q;
        acc_g_d  = acc_g_q;
        acc_b_d  = acc_b_q;

        if (req && !wb.WE_I) begin
            case (adr)
                4'h4: begin
                    dat_o_d = {8'h0, result_q};
                    valid_d = 1'b0;
                end
                4'h8: begin
                    dat_o_d = {29'h0, ovr_q, busy, valid_q};
                    ovr_d   = 1'b0;
                end
                default: dat_o_d = 32'h0;
            endcase
        end

        // A start request during any busy state (including CLIP) is dropped and flagged.
        if (wr_conv) begin
            if (busy) begin
                ovr_d = 1'b1;
            end else begin
                y_d     = wb.DAT_I[23:16];
                cb_d    = wb.DAT_I[15:8];
                cr_d    = wb.DAT_I[7:0];
                state_d = S_M0;
            end
        end

        case (state_q)
            S_M0: begin
                acc_r_d = y_ext + prod_ext;
                state_d = S_M1;
            end
            S_M1: begin
                acc_g_d = y_ext - prod_ext;
                state_d = S_M2;
            end
            S_M2: begin
                acc_g_d = acc_g_q - prod_ext;
                state_d = S_M3;
            end
            S_M3: begin
                acc_b_d = y_ext + prod_ext;
                state_d = S_CLIP;
            end
            S_CLIP: begin
                // Set after any read clear so a coinciding 0x4 read keeps VALID high.
                result_d = {to_chan(acc_r_q), to_chan(acc_g_q), to_chan(acc_b_q)};
                valid_d  = 1'b1;
                state_d  = S_IDLE;
            end
            default: ;
        endcase
    end

    // State register with asynchronous reset; reset abandons any conversion.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q  <= S_IDLE;
            ack_q    <= 1'b0;
            dat_o_q  <= 32'h0;
            result_q <= 24'h0;
            valid_q  <= 1'b0;
            ovr_q    <= 1'b0;
            y_q      <= 8'h0;
            cb_q     <= 8'h0;
            cr_q     <= 8'h0;
            acc_r_q  <= 28'sh0;
            acc_g_q  <= 28'sh0;
            acc_b_q  <= 28'sh0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            dat_o_q  <= dat_o_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
            y_q      <= y_d;
            cb_q     <= cb_d;
            cr_q     <= cr_d;
            acc_r_q  <= acc_r_d;
            acc_g_q  <= acc_g_d;
            acc_b_q  <= acc_b_d;
        end
    end

endmodule
